cam_spi_responder: RTL and testbench

SPI responder emulating the imager's 26-bit register interface: 9-bit address, 1 write bit, 16-bit data, MSB first, CPOL=0/CPHA=0.
- Sits on the far end of the cam_cs/cam_sck/cam_mosi/cam_miso lines driven by spi_master (SCLK_DIV=100, W=26).
- Used in simulation benches and as a loopback target for bring-up of the camera SPI path.
- Holds a 2^AW x DW register file with a side read port for bench/host inspection.

---
 rtl/cam_spi_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_cam_spi_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_spi_responder.sv
// Imager register-interface emulator: 26-bit SPI frames (addr, wr, data), mode 0,
// backed by a cleared-on-reset register file with a side read port.
//  state   | meaning
//  INIT    | clearing register file, one address per cycle (busy)
//  WAIT_CS | frame was open when INIT ended; wait for cs to deassert
//  IDLE    | waiting for cs falling edge
//  SHIFT   | frame open; shifting command/data, driving miso on reads
module cam_spi_responder #(
    parameter int             AW          = 9,
    parameter int             DW          = 16,
    parameter int             SYNC_STAGES = 2,
    parameter logic [DW-1:0]  CHIP_ID     = 16'h5004
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          sck,
    input  logic          mosi,
    output logic          miso,
    output logic          busy,
    input  logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_q,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          frame_err
);

    localparam int DEPTH = 1 << AW;
    localparam int RXW   = (DW > AW + 1) ? DW : AW + 1;

    localparam logic [4:0] CNT_ADDR  = 5'(AW);
    localparam logic [4:0] CNT_CMD   = 5'(AW + 1);
    localparam logic [4:0] CNT_LAST  = 5'(AW + DW);
    localparam logic [4:0] CNT_FRAME = 5'(AW + 1 + DW);
    localparam logic [4:0] CNT_MAX   = 5'd31;

    typedef enum logic [1:0] {
        S_INIT,
        S_WAIT_CS,
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_hist_q, sck_hist_q;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_rise, cs_fall, sck_rise, sck_fall;

    logic [AW-1:0]  init_addr_q, init_addr_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [RXW-1:0] rx_q, rx_d, rx_shift;
    logic [DW-1:0]  tx_q, tx_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           wr_q, wr_d;
    logic           miso_q, miso_d;
    logic           wr_strobe_q, wr_strobe_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [DW-1:0]  wr_data_q, wr_data_d;
    logic           frame_err_q, frame_err_d;
    logic [DW-1:0]  reg_q_q;

    logic [DW-1:0]  mem_q [DEPTH];
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [DW-1:0]  mem_wdata;

    // cs synchronizer idles high so reset never looks like a frame start
    always_ff @(posedge c) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_hist_q   <= 1'b1;
            sck_hist_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_hist_q   <= cs_s;
            sck_hist_q  <= sck_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_rise  = cs_s & ~cs_hist_q;
    assign cs_fall  = ~cs_s & cs_hist_q;
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign rx_shift = {rx_q[RXW-2:0], mosi_s};

    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        case (state_q)
            S_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = init_addr_q;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == '1) begin
                    state_d = cs_s ? S_IDLE : S_WAIT_CS;
                end
            end

            S_WAIT_CS: begin
                miso_d = 1'b0;
                if (cs_s) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                    if (bit_cnt_q == CNT_FRAME) begin
                        if (wr_q && (addr_q != '0)) begin
                            mem_we      = 1'b1;
                            mem_waddr   = addr_q;
                            mem_wdata   = rx_q[DW-1:0];
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = rx_q[DW-1:0];
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        rx_d = rx_shift;
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                        // Command complete: tx is loaded long before the first miso edge
                        if (bit_cnt_q == CNT_ADDR) begin
                            addr_d = rx_shift[AW:1];
                            wr_d   = rx_shift[0];
                            tx_d   = (rx_shift[AW:1] == '0) ? CHIP_ID : mem_q[rx_shift[AW:1]];
                        end
                    end
                    if (sck_fall && !wr_q && (bit_cnt_q >= CNT_CMD) && (bit_cnt_q <= CNT_LAST)) begin
                        miso_d = tx_q[DW-1];
                        tx_d   = {tx_q[DW-2:0], 1'b0};
                    end
                end
            end

            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge c) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge c) begin
        if (!rst_n) begin
            reg_q_q <= '0;
        end else begin
            reg_q_q <= (reg_addr == '0) ? CHIP_ID : mem_q[reg_addr];
        end
    end

    assign miso      = miso_q;
    assign busy      = (state_q == S_INIT);
    assign reg_q     = reg_q_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cam_spi_responder.sv
// Bench for cam_spi_responder: drives mode-0 SPI frames, scoreboards writes,
// frame errors and read data against a reference register-file model.
`timescale 1ns/1ps
module tb_cam_spi_responder;

    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int HALF = 50;
    localparam logic [DW-1:0] CHIP = 16'h5004;

    logic          c = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b1;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic          busy;
    logic [AW-1:0] reg_addr = '0;
    logic [DW-1:0] reg_q;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_err;

    always #5 c = ~c;

    cam_spi_responder dut (
        .c(c), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .busy(busy), .reg_addr(reg_addr), .reg_q(reg_q), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] model [1 << AW];
    wr_t           exp_wr_q [$];
    int            exp_err_q [$];
    logic [DW-1:0] exp_rd_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (a == '0) ? CHIP : model[a];
    endfunction

    // Output monitor: pops the scoreboard on every strobe / error pulse
    logic strobe_prev = 1'b0;
    logic ferr_prev   = 1'b0;
    initial begin
        forever begin
            @(negedge c);
            if (wr_strobe) begin
                check_eq("wr_pending", 32'(exp_wr_q.size() != 0), 1);
                check_eq("wr_1cyc", strobe_prev, 0);
                if (exp_wr_q.size() != 0) begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check_eq("wr_addr", wr_addr, e.a);
                    check_eq("wr_data", wr_data, e.d);
                end
            end
            if (frame_err) begin
                check_eq("ferr_pending", 32'(exp_err_q.size() != 0), 1);
                check_eq("ferr_1cyc", ferr_prev, 0);
                if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
            end
            strobe_prev = wr_strobe;
            ferr_prev   = frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        int cnt;
        @(negedge c);
        rst_n = 1'b0;
        repeat (4) @(negedge c);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_strobe", wr_strobe, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_regq", reg_q, 0);
        check_eq("rst_busy", busy, 1);
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
        rst_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge c);
        end
        check_eq("busy_cycles", cnt, 512);
    endtask

    task automatic spi_xfer(input logic [25:0] word, input int nbits, input bit hold_cs,
                            output logic [25:0] rxd);
        rxd = '0;
        @(negedge c);
        cs = 1'b0;
        repeat (HALF) @(negedge c);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 26) ? word[25 - i] : 1'b0;
            repeat (HALF) @(negedge c);
            sck = 1'b1;
            rxd = {rxd[24:0], miso};
            repeat (HALF) @(negedge c);
            sck = 1'b0;
        end
        if (!hold_cs) begin
            repeat (HALF) @(negedge c);
            cs   = 1'b1;
            mosi = 1'b0;
        end
    endtask

    task automatic frame_done();
        repeat (12) @(negedge c);
        check_eq("wr_drained", exp_wr_q.size(), 0);
        check_eq("err_drained", exp_err_q.size(), 0);
    endtask

    task automatic spi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [25:0] rx;
        wr_t e;
        if (a != '0) begin
            e.a = a;
            e.d = d;
            exp_wr_q.push_back(e);
            model[a] = d;
        end
        spi_xfer({a, 1'b1, d}, 26, 1'b0, rx);
        frame_done();
    endtask

    task automatic spi_read(input logic [AW-1:0] a);
        logic [25:0] rx;
        logic [DW-1:0] e;
        exp_rd_q.push_back(model_rd(a));
        spi_xfer({a, 1'b1 ^ 1'b1, 16'h0000}, 26, 1'b0, rx);
        e = exp_rd_q.pop_front();
        check_eq("rd_data", rx[15:0], e);
        check_eq("rd_cmd_phase", rx[25:16], 0);
        frame_done();
        check_eq("miso_idle", miso, 0);
    endtask

    task automatic side_check(input logic [AW-1:0] a);
        @(negedge c);
        reg_addr = a;
        @(negedge c);
        check_eq("side_rd", reg_q, model_rd(a));
    endtask

    initial begin
        logic [25:0] rx;

        do_reset();
        side_check(9'h001);
        side_check(9'h07A);
        side_check(9'h1FF);
        side_check(9'h000);

        spi_write(9'h07A, 16'h1234);
        side_check(9'h07A);
        spi_read(9'h07A);
        spi_read(9'h000);

        spi_write(9'h000, 16'hBEEF);
        spi_read(9'h000);
        side_check(9'h000);

        exp_err_q.push_back(1);
        spi_xfer({9'h07A, 1'b1, 16'hFFFF}, 20, 1'b0, rx);
        frame_done();
        side_check(9'h07A);

        exp_err_q.push_back(1);
        spi_xfer({9'h010, 1'b1, 16'hFFFF}, 28, 1'b0, rx);
        frame_done();
        side_check(9'h010);

        spi_write(9'h010, 16'h0055);
        side_check(9'h010);
        spi_read(9'h010);

        // Reset lands mid-write with cs still low; the rest of that frame must be ignored
        spi_xfer({9'h003, 1'b1, 16'h5A5A}, 15, 1'b1, rx);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mosi = i[0];
            repeat (HALF) @(negedge c);
            sck = 1'b1;
            repeat (HALF) @(negedge c);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge c);
        cs   = 1'b1;
        mosi = 1'b0;
        frame_done();
        side_check(9'h003);
        side_check(9'h07A);

        spi_write(9'h003, 16'h00A5);
        side_check(9'h003);
        spi_read(9'h003);

        check_eq("rd_q_empty", exp_rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
